// File: rtl/io_ccff_pkg.sv
// io_ccff_pkg: shared state encoding and CRC-16-CCITT helpers for the I/O ccff chain loader.
package io_ccff_pkg;
  typedef enum logic [1:0] {IDLE, LOAD, VERIFY, DONE} state_e;
  localparam logic [15:0] CRC16_POLY = 16'h1021;
  localparam logic [15:0] CRC16_INIT = 16'hFFFF;
  function automatic logic [15:0] crc16_step(input logic [15:0] crc, input logic bit_in);
    return {crc[14:0], 1'b0} ^ ((crc[15] ^ bit_in) ? CRC16_POLY : 16'h0000);
  endfunction
endpackage

// File: rtl/io_ccff_chain_loader_crc16.sv
// ccff_crc16_serial: bit-serial CRC-16-CCITT accumulator, MSB-first, cleared to the CCITT init value.
module ccff_crc16_serial
  import io_ccff_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic        en,
  input  logic        bit_in,
  output logic [15:0] crc
);
  logic [15:0] crc_q, crc_d;
  always_comb crc_d = clr ? CRC16_INIT : en ? crc16_step(crc_q, bit_in) : crc_q;
  always_ff @(posedge clk) crc_q <= rst ? CRC16_INIT : crc_d;
  assign crc = crc_q;
endmodule

// File: rtl/io_ccff_chain_loader.sv
// io_ccff_chain_loader: streams bitstream words into the I/O-tile ccff chain and releases pad isolation once loaded.
// CCFF_READBACK_VERIFY_EN adds a recirculating readback pass with CRC comparison and the error output.
module io_ccff_chain_loader
  import io_ccff_pkg::*;
#(
  parameter int CHAIN_LEN = 72,
  parameter int WORD_W    = 8,
  parameter int CNT_W     = $clog2(CHAIN_LEN + 1)
) (
  input  logic              prog_clk,
  input  logic              prog_reset,
  input  logic              start,
  input  logic [WORD_W-1:0] cfg_data,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  output logic              ccff_head,
  input  logic              ccff_tail,
  output logic              ccff_clk_en,
  output logic              IO_ISOL_N,
  output logic              busy,
`ifdef CCFF_READBACK_VERIFY_EN
  output logic              done,
  output logic              error
`else
  output logic              done
`endif
);
  localparam int IDX_W = WORD_W > 1 ? $clog2(WORD_W) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(CHAIN_LEN - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(WORD_W - 1);
`ifdef CCFF_READBACK_VERIFY_EN
  localparam state_e AFTER_LOAD = VERIFY;
`else
  localparam state_e AFTER_LOAD = DONE;
`endif
  state_e state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WORD_W-1:0] buf_q, buf_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic full_q, full_d, head_q, head_d, en_q, en_d, rb_q, rb_d;
  logic isol_q, isol_d, done_q, done_d, err_d;
  logic go, issue, last_bit, accept, cur_bit, fin;
  assign cur_bit = buf_q[idx_q];
  assign go = start && (state_q == IDLE || state_q == DONE);
  assign issue = state_q == LOAD && full_q;
  assign last_bit = issue && cnt_q == LAST;
  // refill in the same cycle the last buffered bit leaves, unless the chain is then full
  assign cfg_ready = state_q == LOAD && (!full_q || (idx_q == IDX_LAST && !last_bit));
  assign accept = cfg_valid && cfg_ready;
  // rb_q still high means the final readback bit is being captured this cycle
  assign fin = state_q == DONE && !rb_q;

  always_ff @(posedge prog_clk) state_q <= prog_reset ? IDLE : state_d;

  always_comb begin
    state_d = go ? LOAD : last_bit ? AFTER_LOAD : (state_q == VERIFY && cnt_q == LAST) ? DONE : state_q;
  end

  always_comb begin
    cnt_d = (go || last_bit) ? '0 : (issue || state_q == VERIFY) ? cnt_q + CNT_W'(1) : cnt_q;
    idx_d = (go || accept) ? '0 : issue ? idx_q + IDX_W'(1) : idx_q;
    buf_d = accept ? cfg_data : go ? '0 : buf_q;
    full_d = accept || (issue && idx_q != IDX_LAST && !last_bit);
    head_d = issue ? cur_bit : head_q;
    en_d = issue || state_q == VERIFY;
    rb_d = state_q == VERIFY;
    done_d = fin && !go;
    isol_d = fin && !go && !err_d;
  end

  always_ff @(posedge prog_clk) begin
    if (prog_reset) begin
      cnt_q <= '0;
      buf_q <= '0;
      idx_q <= '0;
      full_q <= 1'b0;
      head_q <= 1'b0;
      en_q <= 1'b0;
      rb_q <= 1'b0;
      isol_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      buf_q <= buf_d;
      idx_q <= idx_d;
      full_q <= full_d;
      head_q <= head_d;
      en_q <= en_d;
      rb_q <= rb_d;
      isol_q <= isol_d;
      done_q <= done_d;
    end
  end

`ifdef CCFF_READBACK_VERIFY_EN
  logic err_q;
  logic [15:0] crc_load, crc_rb;
  ccff_crc16_serial u_crc_load (
    .clk(prog_clk), .rst(prog_reset), .clr(go), .en(issue), .bit_in(cur_bit), .crc(crc_load)
  );
  ccff_crc16_serial u_crc_rb (
    .clk(prog_clk), .rst(prog_reset), .clr(go), .en(rb_q), .bit_in(ccff_tail), .crc(crc_rb)
  );
  always_comb err_d = go ? 1'b0 : fin ? crc_load != crc_rb : err_q;
  always_ff @(posedge prog_clk) err_q <= prog_reset ? 1'b0 : err_d;
  assign error = err_q;
`else
  assign err_d = 1'b0;
`endif

  assign ccff_head = rb_q ? ccff_tail : head_q;
  assign ccff_clk_en = en_q;
  assign IO_ISOL_N = isol_q;
  assign busy = state_q == LOAD || state_q == VERIFY;
  assign done = done_q;
endmodule

// File: tb/tb_io_ccff_chain_loader.sv
// tb_io_ccff_chain_loader: scoreboard bench driving a 72-bit and a 20-bit chain loader against chain models.
module tb_io_ccff_chain_loader;
  localparam int N = 72;
  localparam int W = 8;
  localparam int N2 = 20;
`ifdef CCFF_READBACK_VERIFY_EN
  localparam int VER = 1;
`else
  localparam int VER = 0;
`endif
  logic prog_clk = 1'b0;
  logic prog_reset = 1'b1;
  logic start = 1'b0;
  logic cfg_valid = 1'b0;
  logic [W-1:0] cfg_data = '0;
  logic cfg_ready, ccff_head, ccff_tail, ccff_clk_en, io_isol_n, busy, done;
  logic s_start = 1'b0;
  logic s_valid = 1'b0;
  logic [W-1:0] s_data = '0;
  logic s_ready, s_head, s_tail, s_en, s_isol, s_busy, s_done;
`ifdef CCFF_READBACK_VERIFY_EN
  logic error, s_error;
`endif
  int checks = 0;
  int failures = 0;
  string sc = "init";

  always #5 prog_clk = ~prog_clk;

  io_ccff_chain_loader #(.CHAIN_LEN(N), .WORD_W(W)) dut (
    .prog_clk(prog_clk), .prog_reset(prog_reset), .start(start), .cfg_data(cfg_data),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .ccff_head(ccff_head), .ccff_tail(ccff_tail),
    .ccff_clk_en(ccff_clk_en), .IO_ISOL_N(io_isol_n), .busy(busy),
`ifdef CCFF_READBACK_VERIFY_EN
    .done(done), .error(error)
`else
    .done(done)
`endif
  );

  io_ccff_chain_loader #(.CHAIN_LEN(N2), .WORD_W(W)) dut20 (
    .prog_clk(prog_clk), .prog_reset(prog_reset), .start(s_start), .cfg_data(s_data),
    .cfg_valid(s_valid), .cfg_ready(s_ready), .ccff_head(s_head), .ccff_tail(s_tail),
    .ccff_clk_en(s_en), .IO_ISOL_N(s_isol), .busy(s_busy),
`ifdef CCFF_READBACK_VERIFY_EN
    .done(s_done), .error(s_error)
`else
    .done(s_done)
`endif
  );

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s/%s got=%0h exp=%0h", sc, tag, got, exp);
    end
  endtask

  // chain models: index 0 is the head end, the top index drives ccff_tail
  logic [N-1:0] chain = '0;
  logic [N-1:0] stuck_mask = '0;
  logic [N-1:0] exp_chain = '0;
  logic [N2-1:0] s_chain = '0;
  logic [N2-1:0] s_exp = '0;
  assign ccff_tail = chain[N-1];
  assign s_tail = s_chain[N2-1];
  always @(posedge prog_clk) begin
    if (ccff_clk_en) chain <= {chain[N-2:0], ccff_head} & ~stuck_mask;
    if (s_en) s_chain <= {s_chain[N2-2:0], s_head};
  end

  logic sb[$];
  logic s_sb[$];
  int cyc = 0;
  int en_cnt = 0;
  int first_en = -1;
  int last_en = -1;
  int done_cyc = -1;
  int s_en_cnt = 0;
  always @(negedge prog_clk) begin
    cyc++;
    if (ccff_clk_en) begin
      if (first_en < 0) first_en = cyc;
      last_en = cyc;
      if (en_cnt < N) check("head", ccff_head, sb.size() > 0 ? sb.pop_front() : 1'bx);
      else check("rb_head", ccff_head, ccff_tail);
      en_cnt++;
    end
    if (done && done_cyc < 0) done_cyc = cyc;
    if (s_en) begin
      if (s_en_cnt < N2) check("s_head", s_head, s_sb.size() > 0 ? s_sb.pop_front() : 1'bx);
      s_en_cnt++;
    end
  end

  task automatic step();
    @(negedge prog_clk);
    #1;
  endtask

  task automatic reset_mon();
    en_cnt = 0;
    first_en = -1;
    last_en = -1;
    done_cyc = -1;
    sb.delete();
    exp_chain = '0;
  endtask

  task automatic load(input int nw, input int gap_at, input int gap_len, input int start_at, input int abort_at);
    int sent = 0;
    int pushed = 0;
    int gl = gap_len;
    logic [W-1:0] w;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int g = 0; g < 2000 && sent < nw; g++) begin
      if (abort_at >= 0 && en_cnt >= abort_at) break;
      start = start_at >= 0 && en_cnt == start_at;
      if (sent == gap_at && gl > 0 && cfg_ready) begin
        cfg_valid = 1'b0;
        repeat (gl) step();
        gl = 0;
      end
      w = W'(sent * 37 + 8'hA5);
      cfg_data = w;
      cfg_valid = 1'b1;
      if (cfg_ready) begin
        for (int b = 0; b < W; b++)
          if (pushed < N) begin
            sb.push_back(w[b]);
            exp_chain[N-1-pushed] = w[b];
            pushed++;
          end
        sent++;
      end
      step();
    end
    start = 1'b0;
    cfg_valid = 1'b0;
    if (abort_at < 0) check("words", sent, nw);
  endtask

  task automatic wait_done();
    for (int i = 0; i < 400 && !done; i++) step();
    check("done", done, 1'b1);
  endtask

  task automatic check_load(input int bub);
    wait_done();
    check("en_cnt", en_cnt, N * (1 + VER));
    check("bubbles", last_en - first_en + 1 - en_cnt, bub);
    check("done_delay", done_cyc - last_en, 1 + VER);
    check("chain", chain, exp_chain);
    check("outs", {cfg_ready, ccff_clk_en, busy, io_isol_n}, 4'b0001);
    check("sb_left", sb.size(), 0);
`ifdef CCFF_READBACK_VERIFY_EN
    check("error", error, 1'b0);
`endif
  endtask

  logic [W-1:0] w2 [3];
  initial begin
    int acc;
    int p2;
    w2 = '{8'h3C, 8'h96, 8'hFF};
    repeat (3) step();
    sc = "reset";
    check("rst_outs", {cfg_ready, ccff_head, ccff_clk_en, io_isol_n, busy, done}, 6'b0);
    check("s_rst_outs", {s_ready, s_head, s_en, s_isol, s_busy, s_done}, 6'b0);
    prog_reset = 1'b0;
    step();
    sc = "s1_backtoback";
    reset_mon();
    load(9, -1, 0, -1, -1);
    check_load(0);
    sc = "s2_short_chain";
    s_start = 1'b1;
    step();
    s_start = 1'b0;
    acc = 0;
    p2 = 0;
    for (int g = 0; g < 300 && !s_done; g++) begin
      s_valid = 1'b1;
      s_data = acc < 3 ? w2[acc] : 8'h00;
      if (s_ready) begin
        if (acc < 3)
          for (int b = 0; b < W; b++)
            if (p2 < N2) begin
              s_sb.push_back(s_data[b]);
              s_exp[N2-1-p2] = s_data[b];
              p2++;
            end
        acc++;
      end
      step();
    end
    s_valid = 1'b0;
    check("s_done", s_done, 1'b1);
    check("s_words", acc, 3);
    check("s_en_cnt", s_en_cnt, N2 * (1 + VER));
    check("s_chain", s_chain, s_exp);
    check("s_sb_left", s_sb.size(), 0);
    check("s_outs", {s_ready, s_en, s_busy, s_isol}, 4'b0001);
    sc = "s3_gap";
    reset_mon();
    load(9, 4, 5, -1, -1);
    check_load(5);
    sc = "s4_midreset";
    reset_mon();
    load(9, -1, 0, -1, 30);
    check("abort_point", en_cnt >= 30, 1'b1);
    prog_reset = 1'b1;
    step();
    check("rst_outs", {cfg_ready, ccff_head, ccff_clk_en, io_isol_n, busy, done}, 6'b0);
    prog_reset = 1'b0;
    step();
    reset_mon();
    load(9, -1, 0, -1, -1);
    check_load(0);
    sc = "s5_start_busy";
    reset_mon();
    load(9, -1, 0, 20, -1);
    check_load(0);
`ifdef CCFF_READBACK_VERIFY_EN
    sc = "s6_stuck";
    stuck_mask = '0;
    stuck_mask[40] = 1'b1;
    reset_mon();
    load(9, -1, 0, -1, -1);
    wait_done();
    check("en_cnt", en_cnt, 2 * N);
    check("error", error, 1'b1);
    check("isol", io_isol_n, 1'b0);
    stuck_mask = '0;
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end
endmodule
